vc_wrr_lock_arb: RTL and testbench

Parametrised weighted round-robin arbiter with packet locking, built as the successor to the round-robin arbiter chain.
- Each requester gets a programmable number of consecutive transfers per turn, set by its weight.
- A multi-beat transfer holds the grant until its last beat.
- Used in front of shared memory and network ports where multi-beat messages must not interleave.
- With all weights 0 and every beat marked last, behaviour is exactly classic round-robin.

---
 rtl/vc_wrr_lock_arb_if.sv | 25 ++
 rtl/vc_wrr_lock_arb.sv | 99 +++++++++
 tb/tb_vc_wrr_lock_arb.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/vc_wrr_lock_arb_if.sv
// Requester/arbiter handshake bundle for vc_wrr_lock_arb.
// The master drives the requests; the slave (the arbiter) drives the grants.
interface vc_wrr_lock_arb_if #(
  parameter int p_num_reqs    = 4,
  parameter int p_weight_bits = 2,
  parameter int p_id_bits     = $clog2(p_num_reqs)
);
  logic                              en;
  logic [p_num_reqs-1:0]             reqs;
  logic [p_num_reqs-1:0]             lasts;
  logic [p_num_reqs*p_weight_bits-1:0] weights;
  logic [p_num_reqs-1:0]             grants;
  logic [p_id_bits-1:0]              grant_id;
  logic                              locked;

  modport master (
    output en, reqs, lasts, weights,
    input  grants, grant_id, locked
  );

  modport slave (
    input  en, reqs, lasts, weights,
    output grants, grant_id, locked
  );
endinterface

// File: rtl/vc_wrr_lock_arb.sv
// Weighted round-robin arbiter with packet locking: each requester gets weight+1
// transfers per turn, and a multi-beat transfer keeps the grant until its last beat.
module vc_wrr_lock_arb #(
  parameter int p_num_reqs    = 4,
  parameter int p_weight_bits = 2,
  parameter int p_id_bits     = $clog2(p_num_reqs)
) (
  input logic              clk,
  input logic              reset,
  vc_wrr_lock_arb_if.slave bus
);
  typedef enum logic {ST_OPEN, ST_LOCKED} state_t;

  localparam logic [p_id_bits-1:0] lp_last_id = p_id_bits'(p_num_reqs - 1);

  state_t                   r_state, w_state_nxt;
  logic [p_id_bits-1:0]     r_ptr, w_ptr_nxt;
  logic [p_id_bits-1:0]     r_holder, w_holder_nxt;
  logic [p_weight_bits-1:0] r_cnt, w_cnt_nxt;

  logic [p_num_reqs-1:0]    w_grants;
  logic [p_id_bits-1:0]     w_gid;
  logic [p_id_bits-1:0]     w_idx;
  logic                     w_found;
  logic                     w_beat;
  logic [p_weight_bits-1:0] w_weight;
  logic [p_weight_bits-1:0] w_turn_cnt;

  // Grant selection: holder-only while locked, cyclic scan from r_ptr otherwise.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_grants = '0;
    w_gid    = '0;
    w_idx    = '0;
    w_found  = 1'b0;
    if (r_state == ST_LOCKED) begin
      if (bus.reqs[r_holder]) begin
        w_grants[r_holder] = 1'b1;
        w_gid              = r_holder;
      end
    end else begin
      for (int k = 0; k < p_num_reqs; k++) begin
        w_idx = p_id_bits'((int'(r_ptr) + k) % p_num_reqs);
        if (!w_found && bus.reqs[w_idx]) begin
          w_found         = 1'b1;
          w_grants[w_idx] = 1'b1;
          w_gid           = w_idx;
        end
      end
    end
  end

  assign w_beat     = bus.en && (|w_grants);
  assign w_weight   = p_weight_bits'(bus.weights >> (int'(w_gid) * p_weight_bits));
  // A winner that is not the pointer starts a fresh turn.
  assign w_turn_cnt = (w_gid == r_ptr) ? r_cnt : '0;

  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_cnt_nxt    = r_cnt;
    w_holder_nxt = r_holder;
    if (w_beat) begin
      if (!bus.lasts[w_gid]) begin
        w_state_nxt  = ST_LOCKED;
        w_holder_nxt = w_gid;
      end else begin
        w_state_nxt = ST_OPEN;
        // >= rather than == so a weight lowered mid-turn still ends the turn.
        if (w_turn_cnt >= w_weight) begin
          w_ptr_nxt = (w_gid == lp_last_id) ? '0 : w_gid + p_id_bits'(1);
          w_cnt_nxt = '0;
        end else begin
          w_ptr_nxt = w_gid;
          w_cnt_nxt = w_turn_cnt + p_weight_bits'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_OPEN;
      r_ptr    <= '0;
      r_cnt    <= '0;
      r_holder <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples the pre-edge values.
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_cnt    <= w_cnt_nxt;
      r_holder <= w_holder_nxt;
    end
  end

  assign bus.grants   = w_grants;
  assign bus.grant_id = w_gid;
  assign bus.locked   = (r_state == ST_LOCKED);
endmodule

// File: tb/tb_vc_wrr_lock_arb.sv
// Bench for vc_wrr_lock_arb: directed plan steps plus randomized traffic, all
// checked against a behavioural arbitration model kept in plain integers.
module tb_vc_wrr_lock_arb;
  localparam int N  = 4;
  localparam int W  = 2;
  localparam int IB = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vc_wrr_lock_arb_if #(.p_num_reqs(N), .p_weight_bits(W), .p_id_bits(IB)) bus();

  vc_wrr_lock_arb #(.p_num_reqs(N), .p_weight_bits(W), .p_id_bits(IB)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference state: the pointer, turn count, lock flag and lock owner.
  int m_ptr, m_cnt, m_holder;
  bit m_locked;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_ptr    = 0;
    m_cnt    = 0;
    m_holder = 0;
    m_locked = 0;
  endfunction

  // Index of the requester that should win now, -1 for none.
  function automatic int model_grant();
    if (m_locked) return bus.reqs[m_holder] ? m_holder : -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (bus.reqs[j]) return j;
    end
    return -1;
  endfunction

  function automatic void model_edge(input int g);
    int c;
    int w;
    if (bus.en && g >= 0) begin
      if (!bus.lasts[g]) begin
        m_locked = 1;
        m_holder = g;
      end else begin
        m_locked = 0;
        c = (g == m_ptr) ? m_cnt : 0;
        w = int'(bus.weights[g*W +: W]);
        if (c >= w) begin
          m_ptr = (g + 1) % N;
          m_cnt = 0;
        end else begin
          m_ptr = g;
          m_cnt = c + 1;
        end
      end
    end
  endfunction

  // Called just after a negedge with inputs driven; checks, then crosses one posedge.
  task automatic cycle(input string tag, input int lit_g, input int lit_l);
    int g;
    logic [N-1:0] eg;
    #1;
    g  = model_grant();
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    check({tag, ".grants"}, 32'(bus.grants), 32'(eg));
    check({tag, ".grant_id"}, 32'(bus.grant_id), (g < 0) ? 0 : g);
    check({tag, ".locked"}, 32'(bus.locked), 32'(m_locked));
    if (lit_g >= 0) check({tag, ".plan_grants"}, 32'(bus.grants), lit_g);
    if (lit_l >= 0) check({tag, ".plan_locked"}, 32'(bus.locked), lit_l);
    @(posedge clk);
    model_edge(g);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    bus.en      = 1'b0;
    bus.reqs    = '0;
    bus.lasts   = '1;
    bus.weights = '0;
    model_reset();
    #2;
    check("reset.grants", 32'(bus.grants), 0);
    check("reset.grant_id", 32'(bus.grant_id), 0);
    check("reset.locked", 32'(bus.locked), 0);
    @(negedge clk);
    reset = 1'b0;

    // Plan 1: classic round-robin.
    do_reset();
    bus.weights = '0; bus.lasts = 4'b1111; bus.reqs = 4'b1111; bus.en = 1'b1;
    cycle("p1_c0", 4'b0001, 0);
    cycle("p1_c1", 4'b0010, 0);
    cycle("p1_c2", 4'b0100, 0);
    cycle("p1_c3", 4'b1000, 0);
    cycle("p1_c4", 4'b0001, 0);

    // Plan 2: req0 weight 2 -> three transfers per turn.
    do_reset();
    bus.weights = 8'b00_00_00_10; bus.reqs = 4'b0011; bus.lasts = 4'b1111; bus.en = 1'b1;
    cycle("p2_c0", 4'b01, -1);
    cycle("p2_c1", 4'b01, -1);
    cycle("p2_c2", 4'b01, -1);
    cycle("p2_c3", 4'b10, -1);
    cycle("p2_c4", 4'b01, -1);
    cycle("p2_c5", 4'b01, -1);
    cycle("p2_c6", 4'b01, -1);
    cycle("p2_c7", 4'b10, -1);

    // Plan 3: four-beat packet on req0 holds the grant.
    do_reset();
    bus.weights = '0; bus.reqs = 4'b0011; bus.lasts = 4'b0010; bus.en = 1'b1;
    cycle("p3_c1", 4'b01, 0);
    cycle("p3_c2", 4'b01, 1);
    cycle("p3_c3", 4'b01, 1);
    bus.lasts = 4'b0011;
    cycle("p3_c4", 4'b01, 1);
    cycle("p3_c5", 4'b10, 0);

    // Plan 4: holder drops its request mid-packet; nobody else may win.
    do_reset();
    bus.reqs = 4'b0011; bus.lasts = 4'b0010; bus.en = 1'b1;
    cycle("p4_first", 4'b01, 0);
    bus.reqs = 4'b0010;
    cycle("p4_drop0", 4'b00, 1);
    cycle("p4_drop1", 4'b00, 1);
    bus.reqs = 4'b0011; bus.lasts = 4'b0011;
    cycle("p4_resume", 4'b01, 1);
    cycle("p4_next", 4'b10, 0);

    // Plan 5: en low freezes state while grants stay visible.
    do_reset();
    bus.reqs = 4'b0110; bus.lasts = 4'b1111; bus.en = 1'b0;
    cycle("p5_hold0", 4'b0010, 0);
    cycle("p5_hold1", 4'b0010, 0);
    cycle("p5_hold2", 4'b0010, 0);
    bus.en = 1'b1;
    cycle("p5_go0", 4'b0010, 0);
    cycle("p5_go1", 4'b0100, 0);

    // Plan 6: asynchronous reset while req2 holds the lock.
    do_reset();
    bus.reqs = 4'b0100; bus.lasts = 4'b0000; bus.en = 1'b1;
    cycle("p6_lock", 4'b0100, 0);
    #1;
    check("p6_locked_before", 32'(bus.locked), 1);
    #1;
    reset    = 1'b1;
    bus.reqs = 4'b0101;
    model_reset();
    #1;
    check("p6_async.locked", 32'(bus.locked), 0);
    check("p6_async.grants", 32'(bus.grants), 4'b0001);
    check("p6_async.grant_id", 32'(bus.grant_id), 0);
    @(negedge clk);
    reset = 1'b0;
    bus.lasts = 4'b1111;
    cycle("p6_after", 4'b0001, 0);

    // Randomized traffic against the model, with occasional weight changes.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 15) == 0) bus.weights = 8'($urandom);
      bus.reqs = 4'($urandom);
      for (int b = 0; b < N; b++) bus.lasts[b] = ($urandom_range(0, 2) != 0);
      bus.en = ($urandom_range(0, 3) != 0);
      cycle("rand", -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
